// File: rtl/palette_pkg.sv
// Shared types and default sizes for the palette lookup block.
package palette_pkg;

    localparam int DEF_INDEX_W = 4;
    localparam int DEF_CHAN_W  = 4;

    // Fade command encoding carried on fade_cmd.
    typedef enum logic [1:0] {
        CMD_NONE     = 2'b00,
        CMD_FADE_IN  = 2'b01,
        CMD_FADE_OUT = 2'b10,
        CMD_SNAP     = 2'b11
    } fade_cmd_e;

    // Brightness controller states.
    typedef enum logic [1:0] {
        ST_FULL      = 2'b00,
        ST_DARK      = 2'b01,
        ST_RAMP_UP   = 2'b10,
        ST_RAMP_DOWN = 2'b11
    } fade_state_e;

endpackage

// File: rtl/palette_fade.sv
// Brightness fade controller: FSM, step divider and bright register.
// Only compiled when PALETTE_LUT_FADE_EN is defined.
`ifdef PALETTE_LUT_FADE_EN
module palette_fade
    import palette_pkg::*;
#(
    parameter int CHAN_W   = DEF_CHAN_W,
    parameter int FADE_DIV = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        fade_cmd_i,
    output logic [CHAN_W:0]   bright_o,
    output logic              busy_o
);

    localparam int               CNT_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FADE_DIV - 1);
    localparam logic [CHAN_W:0]  BRIGHT_MAX = {1'b1, {CHAN_W{1'b0}}};

    fade_state_e        state_q, state_d;
    logic [CHAN_W:0]    bright_q, bright_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State, brightness and divider registers; reset lands at full brightness.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FULL;
            bright_q <= BRIGHT_MAX;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: commands restart the divider and ramp from the current
    // brightness; a ramp already at its end point goes straight to the terminal state.
    always_comb begin
        state_d  = state_q;
        bright_d = bright_q;
        cnt_d    = cnt_q;
        case (fade_cmd_e'(fade_cmd_i))
            CMD_FADE_IN: begin
                cnt_d   = '0;
                state_d = (bright_q == BRIGHT_MAX) ? ST_FULL : ST_RAMP_UP;
            end
            CMD_FADE_OUT: begin
                cnt_d   = '0;
                state_d = (bright_q == '0) ? ST_DARK : ST_RAMP_DOWN;
            end
            CMD_SNAP: begin
                cnt_d    = '0;
                bright_d = BRIGHT_MAX;
                state_d  = ST_FULL;
            end
            default: begin
                if (state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (state_q == ST_RAMP_UP) begin
                            bright_d = bright_q + 1'b1;
                            if (bright_d == BRIGHT_MAX) state_d = ST_FULL;
                        end else begin
                            bright_d = bright_q - 1'b1;
                            if (bright_d == '0) state_d = ST_DARK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign bright_o = bright_q;
    assign busy_o   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule
`endif

// File: rtl/palette_lut.sv
// Palette lookup table with a 2-cycle read pipeline and optional brightness
// fade. Define PALETTE_LUT_FADE_EN to build in the fade controller and scaler;
// otherwise fade_cmd is ignored and the second stage is a plain register.
module palette_lut
    import palette_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CHAN_W   = DEF_CHAN_W,
    parameter int FADE_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [3*CHAN_W-1:0]   wr_rgb,
    input  logic                  rd_valid_in,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid_out,
    output logic [CHAN_W-1:0]     red,
    output logic [CHAN_W-1:0]     green,
    output logic [CHAN_W-1:0]     blue,
    input  logic [1:0]            fade_cmd,
    output logic                  fade_busy
);

    localparam int DEPTH = 2**INDEX_W;
    localparam int RGB_W = 3*CHAN_W;

    logic [RGB_W-1:0] mem_q [DEPTH];
    logic [RGB_W-1:0] rd_rgb_d;
    logic [RGB_W-1:0] rgb_p1_q;
    logic             vld_p1_q;
    logic [RGB_W-1:0] rgb_p2_d;
    logic [RGB_W-1:0] rgb_p2_q;
    logic             vld_p2_q;

    // Palette storage; reset restores a greyscale ramp on all three channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {3{CHAN_W'(i)}};
            end
        end else if (wr_en) begin
            mem_q[wr_index] <= wr_rgb;
        end
    end

    // Table read with write-first bypass for a same-index write in this cycle.
    always_comb begin
        rd_rgb_d = mem_q[rd_index];
        if (wr_en && (wr_index == rd_index)) rd_rgb_d = wr_rgb;
    end

    // ---- stage 1: registered table read ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            rgb_p1_q <= '0;
        end else begin
            vld_p1_q <= rd_valid_in;
            if (rd_valid_in) rgb_p1_q <= rd_rgb_d;
        end
    end

`ifdef PALETTE_LUT_FADE_EN
    logic [CHAN_W:0] bright;

    palette_fade #(
        .CHAN_W   (CHAN_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade (
        .clk        (clk),
        .reset      (reset),
        .fade_cmd_i (fade_cmd),
        .bright_o   (bright),
        .busy_o     (fade_busy)
    );

    // (c * b) >> CHAN_W, truncated; b at its maximum passes c through unchanged.
    function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                     input logic [CHAN_W:0]   b);
        logic [2*CHAN_W:0] prod;
        prod = {{(CHAN_W+1){1'b0}}, c} * {{CHAN_W{1'b0}}, b};
        return CHAN_W'(prod >> CHAN_W);
    endfunction

    // Brightness scaling of each channel ahead of stage 2.
    always_comb begin
        rgb_p2_d = {scale_chan(rgb_p1_q[3*CHAN_W-1:2*CHAN_W], bright),
                    scale_chan(rgb_p1_q[2*CHAN_W-1:CHAN_W],   bright),
                    scale_chan(rgb_p1_q[CHAN_W-1:0],          bright)};
    end
`else
    logic unused_fade;
    assign unused_fade = (^fade_cmd) ^ (FADE_DIV < 1);
    assign fade_busy   = 1'b0;

    // Without fading, stage 2 carries the table value unchanged.
    always_comb begin
        rgb_p2_d = rgb_p1_q;
    end
`endif

    // ---- stage 2: registered output colour, held while no valid result ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2_q <= 1'b0;
            rgb_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) rgb_p2_q <= rgb_p2_d;
        end
    end

    assign rd_valid_out        = vld_p2_q;
    assign {red, green, blue}  = rgb_p2_q;

endmodule
